// File: rtl/tc_hdd_arbiter.sv
// tc_hdd_arbiter: round-robin two-port front end for a relative-seek HDD.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   rN_req/write/addr/wdata : requester N command (held until rN_ack)
//   rN_ack/err/rdata    : one-cycle completion, range error, read data
//   hdd_seek/load/save/in : HDD head offset, load/save strobes, write data
//   hdd_out             : HDD registered read data
//   busy                : controller not idle
module tc_hdd_arbiter #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic        r0_write,
    input  logic [63:0] r0_addr,
    input  logic [63:0] r0_wdata,
    output logic        r0_ack,
    output logic        r0_err,
    output logic [63:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_write,
    input  logic [63:0] r1_addr,
    input  logic [63:0] r1_wdata,
    output logic        r1_ack,
    output logic        r1_err,
    output logic [63:0] r1_rdata,
    output logic [63:0] hdd_seek,
    output logic        hdd_load,
    output logic        hdd_save,
    output logic [63:0] hdd_in,
    input  logic [63:0] hdd_out,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_ACCESS,
        S_RWAIT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [63:0] r_pos;
    logic        r_last;
    logic        r_sel;
    logic        r_write;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic        r_err;
    logic [63:0] r_rdata0;
    logic [63:0] r_rdata1;

    logic        w_any;
    logic        w_gnt;
    logic        w_gnt_write;
    logic [63:0] w_gnt_addr;
    logic [63:0] w_gnt_wdata;
    logic        w_oor;

    // Tie goes to the port that did not win last time.
    assign w_any       = r0_req | r1_req;
    assign w_gnt       = (r0_req & r1_req) ? ~r_last : r1_req;
    assign w_gnt_write = w_gnt ? r1_write : r0_write;
    assign w_gnt_addr  = w_gnt ? r1_addr  : r0_addr;
    assign w_gnt_wdata = w_gnt ? r1_wdata : r0_wdata;
    assign w_oor       = w_gnt_addr >= 64'(MEM_WORDS);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    if (w_oor) begin
                        w_next = S_DONE;
                    end else if (w_gnt_addr == r_pos) begin
                        w_next = S_ACCESS;
                    end else begin
                        w_next = S_SEEK;
                    end
                end
            end
            S_SEEK:   w_next = S_ACCESS;
            S_ACCESS: w_next = r_write ? S_DONE : S_RWAIT;
            S_RWAIT:  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Request latch, head tracking and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos    <= '0;
            r_last   <= 1'b1;
            r_sel    <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_last  <= w_gnt;
                r_sel   <= w_gnt;
                r_write <= w_gnt_write;
                r_addr  <= w_gnt_addr;
                r_wdata <= w_gnt_wdata;
                r_err   <= w_oor;
            end
            if (r_state == S_SEEK) begin
                r_pos <= r_addr;
            end
            if (r_state == S_RWAIT) begin
                if (r_sel) begin
                    r_rdata1 <= hdd_out;
                end else begin
                    r_rdata0 <= hdd_out;
                end
            end
        end
    end

    // Output logic
    always_comb begin
        hdd_seek = '0;
        hdd_load = 1'b0;
        hdd_save = 1'b0;
        r0_ack   = 1'b0;
        r0_err   = 1'b0;
        r1_ack   = 1'b0;
        r1_err   = 1'b0;
        unique case (r_state)
            S_SEEK: begin
                // Wraps naturally for backward moves.
                hdd_seek = r_addr - r_pos;
            end
            S_ACCESS: begin
                hdd_save = r_write;
                hdd_load = ~r_write;
            end
            S_DONE: begin
                r0_ack = ~r_sel;
                r0_err = ~r_sel & r_err;
                r1_ack = r_sel;
                r1_err = r_sel & r_err;
            end
            default: begin
            end
        endcase
    end

    assign hdd_in   = r_wdata;
    assign r0_rdata = r_rdata0;
    assign r1_rdata = r_rdata1;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: doc/tc_hdd_arbiter.md
Name: tc_hdd_arbiter

Overview:
Two-port arbiter and sequencer for a single 64-bit HDD storage component. The HDD only moves its head by relative offsets (`seek`), reads with one cycle of registered latency (`load`) and writes at the current head (`save`). This block accepts absolute-address read/write requests from two requesters and grants them round-robin. It tracks the head position, converts each absolute address into the relative seek, then issues the load/save and returns data with a one-cycle ack.

Parameters:
- MEM_WORDS, 256, number of HDD words; valid addresses are 0..MEM_WORDS-1.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- r0_req  input  1  requester 0 request; held high with fields stable until r0_ack.
- r0_write  input  1  1 = write, 0 = read.
- r0_addr  input  64  absolute word address.
- r0_wdata  input  64  write data.
- r0_ack  output  1  one-cycle completion pulse.
- r0_err  output  1  valid with r0_ack; 1 = address out of range, no HDD access made.
- r0_rdata  output  64  read data; updated only on a successful read completion for port 0, then held.
- r1_req, r1_write, r1_addr, r1_wdata, r1_ack, r1_err, r1_rdata: same as port 0, for requester 1.
- hdd_seek  output  64  relative head offset to the HDD.
- hdd_load  output  1  HDD load strobe.
- hdd_save  output  1  HDD save strobe.
- hdd_in  output  64  HDD write data.
- hdd_out  input  64  HDD registered read data.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; pos=0; last_grant=1 (port 0 wins the first tie).
  - All outputs are 0: acks, errs, rdata, hdd_seek, hdd_load, hdd_save, hdd_in, busy.
  - A reset during any state aborts the transaction: no ack is issued, and any strobe in flight is dropped from the next cycle.
- Integration requirement: the HDD head is at word 0 when rst deasserts.
- IDLE:
  - If exactly one req is high, grant it. If both are high, grant the port != last_grant. Update last_grant to the granted port.
  - Latch sel, write, addr and wdata.
  - If addr >= MEM_WORDS → DONE with err=1.
  - Else if addr == pos → ACCESS.
  - Else → SEEK.
- SEEK: hdd_seek = lat_addr - pos (64-bit wraparound subtraction); pos <= lat_addr; → ACCESS.
- ACCESS (hdd_seek=0):
  - Write: hdd_save=1 → DONE.
  - Read: hdd_load=1 → RWAIT.
- RWAIT: capture hdd_out into the granted port's rdata at end of cycle; → DONE.
- DONE: pulse ack (and err if flagged) on the granted port only; → IDLE.
- Strobe defaults: hdd_seek=0 outside SEEK; hdd_load/hdd_save=0 outside ACCESS; hdd_in = latched wdata at all times.
- Latency, counted from the IDLE cycle that samples req (cycle 0) to the cycle ack is high:
  - Read with seek: 4.
  - Read without seek: 3.
  - Write with seek: 3.
  - Write without seek: 2.
  - Error: 1.
- Back-to-back requests: a requester changes req/fields on the edge that ends its ack cycle. The IDLE cycle after DONE treats any req as a new request, so no duplicate grant is possible.
- Request changes: req dropping before ack is a protocol violation; the transaction completes anyway. The non-granted port's req is ignored until the next IDLE.
- Error accesses leave pos and rdata unchanged.

Test Plan:
- Reset, then r0 read addr 5 (mem[5]=0xAA) → cycle 1 hdd_seek=5; cycle 2 hdd_load=1; cycle 4 r0_ack=1, r0_rdata=0xAA, r0_err=0.
- r1 write addr 5 data 0x1234 when pos=5 → no seek (hdd_seek stays 0); cycle 1 hdd_save=1, hdd_in=0x1234; cycle 2 r1_ack; a following read of 5 returns 0x1234.
- pos=10, r0 read addr 3 → hdd_seek=0xFFFF_FFFF_FFFF_FFF9 (-7) for one cycle; pos becomes 3.
- Both req high from reset, held continuously → grants alternate r0, r1, r0, r1; each ack goes only to its own port.
- r0 read addr 256 (MEM_WORDS=256) → r0_ack and r0_err high at cycle 1; no hdd strobes; pos and r0_rdata unchanged.
- rst asserted in the ACCESS cycle of a write → no ack; all outputs 0 next cycle; pos=0; busy=0.
